// File: rtl/expr_pkg.sv
// Shared definitions for the expression recognizer: FSM state encoding,
// character classes and the ASCII codes the grammar is built from.
package expr_pkg;

  typedef enum logic [2:0] {
    S_START   = 3'd0,  // expecting a TERM at the start of an expression
    S_NUM     = 3'd1,  // inside a number
    S_OP      = 3'd2,  // after an operator, expecting a TERM
    S_CLOSE   = 3'd3,  // after ')'
    S_NUM_END = 3'd4,  // number ended by a space; only OP or ')' may follow
    S_ERR     = 3'd5   // absorbing error state
  } state_t;

  typedef enum logic [2:0] {
    C_DIGIT   = 3'd0,
    C_OP      = 3'd1,
    C_OPEN    = 3'd2,
    C_CLOSE   = 3'd3,
    C_SPACE   = 3'd4,
    C_ILLEGAL = 3'd5
  } cls_t;

  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_NINE   = 8'h39;
  localparam logic [7:0] CH_PLUS   = 8'h2B;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_LPAREN = 8'h28;
  localparam logic [7:0] CH_RPAREN = 8'h29;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  // States in which the characters seen so far end a complete operand.
  function automatic logic accepting(state_t s);
    return (s == S_NUM) || (s == S_CLOSE) || (s == S_NUM_END);
  endfunction

endpackage

// File: rtl/expr_recognizer_char_class.sv
// Combinational character classifier. '-' and '*' count as operators only
// when enabled; otherwise they fall through to the illegal class.
module char_class
  import expr_pkg::*;
#(
  parameter int ALLOW_SUB = 1,
  parameter int ALLOW_MUL = 1
) (
  input  logic [7:0] ch,
  output logic [2:0] cls
);

  // Map one ASCII character to its grammar class.
  always_comb begin
    // NOTE: default assignment first so every path drives cls and no latch is inferred.
    cls = C_ILLEGAL;
    if (ch >= CH_ZERO && ch <= CH_NINE)                cls = C_DIGIT;
    else if (ch == CH_PLUS)                            cls = C_OP;
    else if ((ALLOW_SUB != 0) && (ch == CH_MINUS))     cls = C_OP;
    else if ((ALLOW_MUL != 0) && (ch == CH_STAR))      cls = C_OP;
    else if (ch == CH_LPAREN)                          cls = C_OPEN;
    else if (ch == CH_RPAREN)                          cls = C_CLOSE;
    else if (ch == CH_SPACE)                           cls = C_SPACE;
  end

endmodule

// File: rtl/expr_recognizer.sv
// Streaming recognizer for arithmetic expressions of numbers, operators and
// parentheses. One character per qualified clock edge; out/err/depth are
// registered and describe everything consumed since the last clr.
module expr_recognizer
  import expr_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int MAX_DEPTH  = 7,
  parameter int ALLOW_SUB  = 1,
  parameter int ALLOW_MUL  = 1
) (
  input  logic                             clk,
  input  logic                             clr,
  input  logic                             in_valid,
  input  logic [7:0]                       in,
  output logic                             out,
  output logic                             err,
  output logic [$clog2(MAX_DEPTH+1)-1:0]   depth
);

  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam int CW = $clog2(MAX_DIGITS + 1);

  state_t         state, nxt_state;
  logic [CW-1:0]  cnt, nxt_cnt;
  logic [DW-1:0]  nxt_depth;
  logic [2:0]     cls_raw;
  cls_t           cls;

  char_class #(
    .ALLOW_SUB (ALLOW_SUB),
    .ALLOW_MUL (ALLOW_MUL)
  ) u_char_class (
    .ch  (in),
    .cls (cls_raw)
  );

  assign cls = cls_t'(cls_raw);

  // Next state, digit count and nesting depth for the current character.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_depth = depth;
    if (in_valid) begin
      unique case (state)
        S_START, S_OP: begin
          unique case (cls)
            C_DIGIT: begin
              nxt_state = S_NUM;
              nxt_cnt   = CW'(1);
            end
            C_OPEN: begin
              if (depth == DW'(MAX_DEPTH)) nxt_state = S_ERR;
              else                          nxt_depth = depth + DW'(1);
            end
            C_SPACE: ;
            default: nxt_state = S_ERR;
          endcase
        end
        S_NUM: begin
          unique case (cls)
            C_DIGIT: begin
              if (cnt == CW'(MAX_DIGITS)) nxt_state = S_ERR;
              else                         nxt_cnt   = cnt + CW'(1);
            end
            C_OP: begin
              nxt_state = S_OP;
              nxt_cnt   = '0;
            end
            C_CLOSE: begin
              nxt_cnt = '0;
              if (depth == '0) nxt_state = S_ERR;
              else begin
                nxt_state = S_CLOSE;
                nxt_depth = depth - DW'(1);
              end
            end
            C_SPACE: begin
              nxt_state = S_NUM_END;
              nxt_cnt   = '0;
            end
            default: nxt_state = S_ERR;
          endcase
        end
        S_CLOSE, S_NUM_END: begin
          unique case (cls)
            C_OP:    nxt_state = S_OP;
            C_CLOSE: begin
              if (depth == '0) nxt_state = S_ERR;
              else begin
                nxt_state = S_CLOSE;
                nxt_depth = depth - DW'(1);
              end
            end
            C_SPACE: ;
            default: nxt_state = S_ERR;
          endcase
        end
        default: ;  // S_ERR holds everything, depth included
      endcase
    end
  end

  // State and registered Moore outputs derived from the next state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_START;
      cnt   <= '0;
      depth <= '0;
      out   <= 1'b0;
      err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from pre-edge values.
      state <= nxt_state;
      cnt   <= nxt_cnt;
      depth <= nxt_depth;
      out   <= accepting(nxt_state) && (nxt_depth == '0);
      err   <= (nxt_state == S_ERR);
    end
  end

endmodule

// File: tb/tb_expr_recognizer.sv
// Self-checking bench for expr_recognizer: two instances (default and a
// tight configuration) share one input stream; directed scenarios check
// fixed expectations, a random phase compares against a token-level model.
module tb_expr_recognizer;

  logic       clk = 1'b0;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_ch;

  logic       out_a, err_a;
  logic [2:0] depth_a;
  logic       out_b, err_b;
  logic [1:0] depth_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  expr_recognizer dut_a (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in       (in_ch),
    .out      (out_a),
    .err      (err_a),
    .depth    (depth_a)
  );

  expr_recognizer #(
    .MAX_DIGITS (2),
    .MAX_DEPTH  (2),
    .ALLOW_SUB  (0),
    .ALLOW_MUL  (0)
  ) dut_b (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in       (in_ch),
    .out      (out_b),
    .err      (err_b),
    .depth    (depth_b)
  );

  // Token-level reference: tracks whether a term is expected, the length
  // of the number being read, whether a space has ended it, and nesting.
  typedef struct {
    bit err;
    int depth;
    bit expect_term;
    int run;
    bit gap;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_reset();
    model_t m;
    m.err = 0; m.depth = 0; m.expect_term = 1; m.run = 0; m.gap = 0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, byte unsigned c, int max_digits,
                                        int max_depth, bit sub, bit mul);
    bit is_digit;
    bit is_op;
    is_digit = (c >= "0") && (c <= "9");
    is_op    = (c == "+") || (sub && c == "-") || (mul && c == "*");
    if (m.err) return m;
    if (c == " ") begin
      if (!m.expect_term && m.run > 0) m.gap = 1;
    end else if (is_digit) begin
      if (m.expect_term) begin
        m.expect_term = 0; m.run = 1; m.gap = 0;
      end else if (m.run > 0 && !m.gap && m.run < max_digits) m.run++;
      else m.err = 1;
    end else if (c == "(") begin
      if (m.expect_term && m.depth < max_depth) m.depth++;
      else m.err = 1;
    end else if (c == ")") begin
      if (!m.expect_term && m.depth > 0) begin
        m.depth--; m.run = 0; m.gap = 0;
      end else m.err = 1;
    end else if (is_op) begin
      if (!m.expect_term) begin
        m.expect_term = 1; m.run = 0; m.gap = 0;
      end else m.err = 1;
    end else m.err = 1;
    return m;
  endfunction

  function automatic bit model_out(model_t m);
    return !m.err && !m.expect_term && (m.depth == 0);
  endfunction

  // Present one character at the falling edge; return just after the rising edge.
  task automatic send(input byte unsigned c, input bit v);
    @(negedge clk);
    in_ch    = c;
    in_valid = v;
    @(posedge clk);
    #1;
    if (v) begin
      ma = model_step(ma, c, 4, 7, 1, 1);
      mb = model_step(mb, c, 2, 2, 0, 0);
    end
  endtask

  // Asynchronous clear pulse placed between clock edges.
  task automatic reset_dut();
    @(negedge clk);
    in_valid = 1'b0;
    clr = 1'b1;
    #2;
    clr = 1'b0;
    ma = model_reset();
    mb = model_reset();
  endtask

  task automatic test_reset();
    clr = 1'b1; in_valid = 1'b0; in_ch = 8'h00;
    #3;
    checks++; if (out_a !== 1'b0)   begin failures++; $display("FAIL reset.out_a got=%b exp=0", out_a); end
    checks++; if (err_a !== 1'b0)   begin failures++; $display("FAIL reset.err_a got=%b exp=0", err_a); end
    checks++; if (depth_a !== 3'd0) begin failures++; $display("FAIL reset.depth_a got=%0d exp=0", depth_a); end
    checks++; if (out_b !== 1'b0)   begin failures++; $display("FAIL reset.out_b got=%b exp=0", out_b); end
    checks++; if (err_b !== 1'b0)   begin failures++; $display("FAIL reset.err_b got=%b exp=0", err_b); end
    checks++; if (depth_b !== 2'd0) begin failures++; $display("FAIL reset.depth_b got=%0d exp=0", depth_b); end
    @(negedge clk);
    clr = 1'b0;
    ma = model_reset();
    mb = model_reset();
  endtask

  task automatic test_sum();
    string s = "1+1+";
    bit eo[4] = '{1, 0, 1, 0};
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      send(s[i], 1'b1);
      checks++; if (out_a !== eo[i]) begin failures++; $display("FAIL sum.out[%0d] got=%b exp=%b", i, out_a, eo[i]); end
      checks++; if (err_a !== 1'b0)  begin failures++; $display("FAIL sum.err[%0d] got=%b exp=0", i, err_a); end
    end
  endtask

  task automatic test_paren();
    string s = "(12*3)";
    logic [2:0] ed[6] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    bit         eo[6] = '{0, 0, 0, 0, 0, 1};
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      send(s[i], 1'b1);
      checks++; if (depth_a !== ed[i]) begin failures++; $display("FAIL paren.depth[%0d] got=%0d exp=%0d", i, depth_a, ed[i]); end
      checks++; if (out_a !== eo[i])   begin failures++; $display("FAIL paren.out[%0d] got=%b exp=%b", i, out_a, eo[i]); end
    end
  endtask

  task automatic test_digits();
    string s = "12345+1";
    bit ea[7] = '{0, 0, 0, 0, 1, 1, 1};
    bit eb[7] = '{0, 0, 1, 1, 1, 1, 1};
    reset_dut();
    for (int i = 0; i < 7; i++) begin
      send(s[i], 1'b1);
      checks++; if (err_a !== ea[i]) begin failures++; $display("FAIL digits.err_a[%0d] got=%b exp=%b", i, err_a, ea[i]); end
      checks++; if (err_b !== eb[i]) begin failures++; $display("FAIL digits.err_b[%0d] got=%b exp=%b", i, err_b, eb[i]); end
    end
    checks++; if (out_a !== 1'b0) begin failures++; $display("FAIL digits.out_a got=%b exp=0", out_a); end
  endtask

  task automatic test_depth();
    string s = "(((";
    bit         ee[3] = '{0, 0, 1};
    logic [1:0] ed[3] = '{2'd1, 2'd2, 2'd2};
    reset_dut();
    send(")", 1'b1);
    checks++; if (err_a !== 1'b1)   begin failures++; $display("FAIL depth.close_err got=%b exp=1", err_a); end
    checks++; if (depth_a !== 3'd0) begin failures++; $display("FAIL depth.close_depth got=%0d exp=0", depth_a); end
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      send(s[i], 1'b1);
      checks++; if (err_b !== ee[i])   begin failures++; $display("FAIL depth.open_err[%0d] got=%b exp=%b", i, err_b, ee[i]); end
      checks++; if (depth_b !== ed[i]) begin failures++; $display("FAIL depth.open_depth[%0d] got=%0d exp=%0d", i, depth_b, ed[i]); end
    end
    checks++; if (depth_a !== 3'd3) begin failures++; $display("FAIL depth.a_three got=%0d exp=3", depth_a); end
  endtask

  task automatic test_ops();
    reset_dut();
    send("7", 1'b1);
    checks++; if (out_a !== 1'b1) begin failures++; $display("FAIL ops.out_7 got=%b exp=1", out_a); end
    send("-", 1'b1);
    checks++; if (out_a !== 1'b0) begin failures++; $display("FAIL ops.out_minus got=%b exp=0", out_a); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL ops.err_a_minus got=%b exp=0", err_a); end
    checks++; if (err_b !== 1'b1) begin failures++; $display("FAIL ops.err_b_minus got=%b exp=1", err_b); end
    reset_dut();
    send("7", 1'b1);
    send("*", 1'b1);
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL ops.err_a_star got=%b exp=0", err_a); end
    checks++; if (err_b !== 1'b1) begin failures++; $display("FAIL ops.err_b_star got=%b exp=1", err_b); end
  endtask

  task automatic test_space_hold();
    reset_dut();
    send("(", 1'b1);
    send("5", 1'b1);
    send(" ", 1'b1);
    for (int i = 0; i < 4; i++) send(8'($urandom_range(32, 126)), 1'b0);
    checks++; if (depth_a !== 3'd1) begin failures++; $display("FAIL hold.depth got=%0d exp=1", depth_a); end
    checks++; if (err_a !== 1'b0)   begin failures++; $display("FAIL hold.err got=%b exp=0", err_a); end
    send("6", 1'b1);
    checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL space.digit_after_gap got=%b exp=1", err_a); end
    reset_dut();
    send("5", 1'b1);
    send(" ", 1'b1);
    send(" ", 1'b1);
    checks++; if (out_a !== 1'b1) begin failures++; $display("FAIL space.out_num_end got=%b exp=1", out_a); end
  endtask

  task automatic test_async_clr();
    reset_dut();
    send("9", 1'b1);
    send("+", 1'b1);
    send("(", 1'b1);
    send("(", 1'b1);
    send("x", 1'b1);
    checks++; if (err_a !== 1'b1 || depth_a !== 3'd2) begin failures++; $display("FAIL clr.pre err=%b depth=%0d exp err=1 depth=2", err_a, depth_a); end
    #2;
    clr = 1'b1;
    #1;
    checks++; if (err_a !== 1'b0)   begin failures++; $display("FAIL clr.err_a got=%b exp=0", err_a); end
    checks++; if (depth_a !== 3'd0) begin failures++; $display("FAIL clr.depth_a got=%0d exp=0", depth_a); end
    checks++; if (err_b !== 1'b0)   begin failures++; $display("FAIL clr.err_b got=%b exp=0", err_b); end
    checks++; if (depth_b !== 2'd0) begin failures++; $display("FAIL clr.depth_b got=%0d exp=0", depth_b); end
    clr = 1'b0;
    ma = model_reset();
    mb = model_reset();
    send("4", 1'b1);
    checks++; if (out_a !== 1'b1) begin failures++; $display("FAIL clr.out_a_after got=%b exp=1", out_a); end
    checks++; if (out_b !== 1'b1) begin failures++; $display("FAIL clr.out_b_after got=%b exp=1", out_b); end
  endtask

  task automatic test_random();
    byte unsigned c;
    int r;
    bit v;
    reset_dut();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0) reset_dut();
      r = int'($urandom_range(0, 99));
      if      (r < 40) c = 8'(32'h30 + $urandom_range(0, 9));
      else if (r < 53) c = "(";
      else if (r < 66) c = ")";
      else if (r < 74) c = "+";
      else if (r < 80) c = "-";
      else if (r < 86) c = "*";
      else if (r < 96) c = " ";
      else             c = 8'(32'h41 + $urandom_range(0, 25));
      v = ($urandom_range(0, 9) != 0);
      send(c, v);
      checks++; if (out_a !== model_out(ma))        begin failures++; $display("FAIL rand.out_a[%0d] got=%b exp=%b", n, out_a, model_out(ma)); end
      checks++; if (err_a !== ma.err)               begin failures++; $display("FAIL rand.err_a[%0d] got=%b exp=%b", n, err_a, ma.err); end
      checks++; if (depth_a !== 3'(ma.depth))       begin failures++; $display("FAIL rand.depth_a[%0d] got=%0d exp=%0d", n, depth_a, ma.depth); end
      checks++; if (out_b !== model_out(mb))        begin failures++; $display("FAIL rand.out_b[%0d] got=%b exp=%b", n, out_b, model_out(mb)); end
      checks++; if (err_b !== mb.err)               begin failures++; $display("FAIL rand.err_b[%0d] got=%b exp=%b", n, err_b, mb.err); end
      checks++; if (depth_b !== 2'(mb.depth))       begin failures++; $display("FAIL rand.depth_b[%0d] got=%0d exp=%0d", n, depth_b, mb.depth); end
    end
  endtask

  initial begin
    ma = model_reset();
    mb = model_reset();
    test_reset();
    test_sum();
    test_paren();
    test_digits();
    test_depth();
    test_ops();
    test_space_hold();
    test_async_clr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
